// File: rtl/riscv_test_monitor_if.sv
// Tap bundle between a Core under test and its pass/fail/timeout monitor.
// The master side drives the core taps; the slave side (the monitor) returns the verdict.
interface riscv_test_monitor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic              start;
    logic [XLEN-1:0]   gp_val;
    logic              ecall_ret;
    logic              st_valid;
    logic [XLEN-1:0]   st_addr;
    logic [XLEN-1:0]   st_data;
    logic [3:0]        st_be;

    logic              done;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [XLEN-2:0]   fail_testnum;
    logic [CNT_W-1:0]  cycles;

    modport master (
        output start, gp_val, ecall_ret, st_valid, st_addr, st_data, st_be,
        input  done, pass, fail, timeout, fail_testnum, cycles
    );

    modport slave (
        input  start, gp_val, ecall_ret, st_valid, st_addr, st_data, st_be,
        output done, pass, fail, timeout, fail_testnum, cycles
    );
endinterface

// File: rtl/riscv_test_monitor.sv
// Event-driven riscv-tests completion monitor: watches gp+ecall or a tohost store,
// counts cycles from start and latches a PASS / FAIL / TIMEOUT verdict.
module riscv_test_monitor #(
    parameter int              XLEN        = 32,
    parameter int              MODE        = 0,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 'h0000_1000,
    parameter int              TIMEOUT     = 5000,
    parameter int              CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    riscv_test_monitor_if.slave  mon
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PASS,
        FAIL,
        TMO
    } state_e;

    localparam logic [XLEN-1:0]  WORD_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0]  PASS_VAL  = XLEN'(1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic [XLEN-2:0]   testnum_q, testnum_d;

    logic              evt_gp, evt_st, evt, tmo_hit;
    logic [XLEN-1:0]   rpt;

    always_comb begin
        evt_gp  = mon.ecall_ret && (mon.gp_val != '0);
        evt_st  = mon.st_valid
                  && ((mon.st_addr & WORD_MASK) == (TOHOST_ADDR & WORD_MASK))
                  && (mon.st_be == 4'hF)
                  && mon.st_data[0];
        evt     = (MODE == 0) ? evt_gp : evt_st;
        rpt     = (MODE == 0) ? mon.gp_val : mon.st_data;
        tmo_hit = (TIMEOUT != 0) && (cycles_q == TMO_LAST);
    end

    // A restart takes priority over anything seen in the same cycle; an event beats the timeout.
    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        testnum_d = testnum_q;
        case (state_q)
            RUN: begin
                if (mon.start) begin
                    cycles_d = '0;
                end else if (evt) begin
                    if (rpt == PASS_VAL) begin
                        state_d = PASS;
                    end else begin
                        state_d   = FAIL;
                        testnum_d = rpt[XLEN-1:1];
                    end
                end else if (tmo_hit) begin
                    state_d = TMO;
                end else begin
                    cycles_d = sat_inc(cycles_q);
                end
            end
            default: begin
                if (mon.start) begin
                    state_d   = RUN;
                    cycles_d  = '0;
                    testnum_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cycles_q  <= '0;
            testnum_q <= '0;
        end else begin
            state_q   <= state_d;
            cycles_q  <= cycles_d;
            testnum_q <= testnum_d;
        end
    end

    // Verdict flags decode straight from the state, so exactly one is set whenever done is.
    assign mon.done         = (state_q == PASS) || (state_q == FAIL) || (state_q == TMO);
    assign mon.pass         = (state_q == PASS);
    assign mon.fail         = (state_q == FAIL);
    assign mon.timeout      = (state_q == TMO);
    assign mon.fail_testnum = testnum_q;
    assign mon.cycles       = cycles_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: four configurations share one stimulus stream and are
// checked every cycle against a behavioural model, plus hand-computed expectations.
module tb_riscv_test_monitor;

    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, ecall = 1'b0, st_valid = 1'b0;
    logic [31:0] gp = '0, st_addr = '0, st_data = '0;
    logic [3:0]  st_be = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_test_monitor_if #(.XLEN(32), .CNT_W(32)) if0 ();
    riscv_test_monitor_if #(.XLEN(32), .CNT_W(32)) if1 ();
    riscv_test_monitor_if #(.XLEN(32), .CNT_W(32)) if2 ();
    riscv_test_monitor_if #(.XLEN(32), .CNT_W(4))  if3 ();

    assign if0.start = start; assign if0.gp_val = gp; assign if0.ecall_ret = ecall;
    assign if0.st_valid = st_valid; assign if0.st_addr = st_addr; assign if0.st_data = st_data; assign if0.st_be = st_be;
    assign if1.start = start; assign if1.gp_val = gp; assign if1.ecall_ret = ecall;
    assign if1.st_valid = st_valid; assign if1.st_addr = st_addr; assign if1.st_data = st_data; assign if1.st_be = st_be;
    assign if2.start = start; assign if2.gp_val = gp; assign if2.ecall_ret = ecall;
    assign if2.st_valid = st_valid; assign if2.st_addr = st_addr; assign if2.st_data = st_data; assign if2.st_be = st_be;
    assign if3.start = start; assign if3.gp_val = gp; assign if3.ecall_ret = ecall;
    assign if3.st_valid = st_valid; assign if3.st_addr = st_addr; assign if3.st_data = st_data; assign if3.st_be = st_be;

    riscv_test_monitor #(.XLEN(32), .MODE(0), .TOHOST_ADDR(TOHOST), .TIMEOUT(100), .CNT_W(32))
        u0 (.clk(clk), .rst(rst), .mon(if0));
    riscv_test_monitor #(.XLEN(32), .MODE(1), .TOHOST_ADDR(TOHOST), .TIMEOUT(100), .CNT_W(32))
        u1 (.clk(clk), .rst(rst), .mon(if1));
    riscv_test_monitor #(.XLEN(32), .MODE(0), .TOHOST_ADDR(TOHOST), .TIMEOUT(0), .CNT_W(32))
        u2 (.clk(clk), .rst(rst), .mon(if2));
    riscv_test_monitor #(.XLEN(32), .MODE(0), .TOHOST_ADDR(TOHOST), .TIMEOUT(0), .CNT_W(4))
        u3 (.clk(clk), .rst(rst), .mon(if3));

    logic        a_done [4];
    logic        a_pass [4];
    logic        a_fail [4];
    logic        a_tmo  [4];
    logic [30:0] a_num  [4];
    logic [31:0] a_cyc  [4];

    assign a_done[0] = if0.done; assign a_pass[0] = if0.pass; assign a_fail[0] = if0.fail;
    assign a_tmo[0] = if0.timeout; assign a_num[0] = if0.fail_testnum; assign a_cyc[0] = if0.cycles;
    assign a_done[1] = if1.done; assign a_pass[1] = if1.pass; assign a_fail[1] = if1.fail;
    assign a_tmo[1] = if1.timeout; assign a_num[1] = if1.fail_testnum; assign a_cyc[1] = if1.cycles;
    assign a_done[2] = if2.done; assign a_pass[2] = if2.pass; assign a_fail[2] = if2.fail;
    assign a_tmo[2] = if2.timeout; assign a_num[2] = if2.fail_testnum; assign a_cyc[2] = if2.cycles;
    assign a_done[3] = if3.done; assign a_pass[3] = if3.pass; assign a_fail[3] = if3.fail;
    assign a_tmo[3] = if3.timeout; assign a_num[3] = if3.fail_testnum; assign a_cyc[3] = {28'b0, if3.cycles};

    function automatic bit cfg_mode1(input int i);
        return (i == 1);
    endfunction
    function automatic longint cfg_timeout(input int i);
        return (i < 2) ? 100 : 0;
    endfunction
    function automatic longint cfg_max(input int i);
        return (i == 3) ? 15 : 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Model: a run counts elapsed cycles; the first qualifying report ends it with a verdict.
    bit     m_run  [4] = '{default: 1'b0};
    bit     m_done [4] = '{default: 1'b0};
    bit     m_pass [4] = '{default: 1'b0};
    bit     m_fail [4] = '{default: 1'b0};
    bit     m_tmo  [4] = '{default: 1'b0};
    longint m_num  [4] = '{default: 0};
    longint m_cyc  [4] = '{default: 0};

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 4; i++) begin
            bit     ev;
            longint r;
            if (!rst) begin
                m_run[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_tmo[i] = 0;
                m_num[i] = 0; m_cyc[i] = 0;
            end else if (start) begin
                m_run[i] = 1; m_done[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_tmo[i] = 0;
                m_num[i] = 0; m_cyc[i] = 0;
            end else if (m_run[i]) begin
                if (cfg_mode1(i)) begin
                    ev = st_valid && (st_addr / 4 == TOHOST / 4) && (st_be == 4'hF) && (st_data % 2 == 1);
                    r  = longint'(st_data);
                end else begin
                    ev = ecall && (gp != 0);
                    r  = longint'(gp);
                end
                if (ev) begin
                    m_run[i] = 0; m_done[i] = 1;
                    if (r == 1) m_pass[i] = 1;
                    else begin
                        m_fail[i] = 1; m_num[i] = r / 2;
                    end
                end else if (cfg_timeout(i) != 0 && m_cyc[i] == cfg_timeout(i) - 1) begin
                    m_run[i] = 0; m_done[i] = 1; m_tmo[i] = 1;
                end else if (m_cyc[i] < cfg_max(i)) begin
                    m_cyc[i] = m_cyc[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("u%0d.done", i),    64'(a_done[i]), 64'(m_done[i]));
            chk($sformatf("u%0d.pass", i),    64'(a_pass[i]), 64'(m_pass[i]));
            chk($sformatf("u%0d.fail", i),    64'(a_fail[i]), 64'(m_fail[i]));
            chk($sformatf("u%0d.timeout", i), 64'(a_tmo[i]),  64'(m_tmo[i]));
            chk($sformatf("u%0d.testnum", i), 64'(a_num[i]),  64'(m_num[i]));
            chk($sformatf("u%0d.cycles", i),  64'(a_cyc[i]),  64'(m_cyc[i]));
        end
    end

    task automatic idle_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 0; ecall = 0; st_valid = 0; gp = '0; st_be = '0;
        end
    endtask

    task automatic go();
        @(negedge clk);
        start = 1; ecall = 0; st_valid = 0;
    endtask

    task automatic ecall_ev(input logic [31:0] v);
        @(negedge clk);
        start = 0; st_valid = 0; ecall = 1; gp = v;
    endtask

    task automatic store_ev(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        start = 0; ecall = 0; st_valid = 1; st_addr = a; st_data = d; st_be = be;
    endtask

    initial begin
        #1 rst = 0;
        idle_cyc(2);
        chk("reset_done", 64'(a_done[0]), 64'd0);
        chk("reset_cycles", 64'(a_cyc[0]), 64'd0);
        rst = 1;

        ecall_ev(32'd1); idle_cyc(1);
        chk("idle_ignores_ecall", 64'(a_done[0]), 64'd0);

        go(); idle_cyc(20);
        ecall_ev(32'd0); idle_cyc(1);
        chk("gp0_ecall_ignored", 64'(a_done[0]), 64'd0);
        idle_cyc(17);
        ecall_ev(32'd1); idle_cyc(1);
        chk("pass39_done", 64'(a_done[0]), 64'd1);
        chk("pass39_pass", 64'(a_pass[0]), 64'd1);
        chk("pass39_fail", 64'(a_fail[0]), 64'd0);
        chk("pass39_cycles", 64'(a_cyc[0]), 64'd39);

        go(); idle_cyc(5);
        ecall_ev(32'h0000_0007); idle_cyc(1);
        chk("fail7_fail", 64'(a_fail[0]), 64'd1);
        chk("fail7_testnum", 64'(a_num[0]), 64'd3);

        go(); idle_cyc(9);
        ecall_ev(32'd1); idle_cyc(1);
        chk("restart_pass", 64'(a_pass[0]), 64'd1);
        chk("restart_fail_clear", 64'(a_fail[0]), 64'd0);
        chk("restart_cycles", 64'(a_cyc[0]), 64'd9);

        go(); idle_cyc(2);
        store_ev(TOHOST, 32'd2, 4'hF); idle_cyc(1);
        chk("tohost_even", 64'(a_done[1]), 64'd0);
        store_ev(TOHOST + 32'd8, 32'd1, 4'hF); idle_cyc(1);
        chk("tohost_other_addr", 64'(a_done[1]), 64'd0);
        store_ev(TOHOST, 32'd1, 4'h3); idle_cyc(1);
        chk("tohost_partial_be", 64'(a_done[1]), 64'd0);
        store_ev(TOHOST + 32'd2, 32'd1, 4'hF); idle_cyc(1);
        chk("tohost_pass", 64'(a_pass[1]), 64'd1);
        chk("tohost_cycles", 64'(a_cyc[1]), 64'd8);

        go(); idle_cyc(110);
        chk("tmo_timeout", 64'(a_tmo[0]), 64'd1);
        chk("tmo_done", 64'(a_done[0]), 64'd1);
        chk("tmo_cycles", 64'(a_cyc[0]), 64'd99);

        go(); idle_cyc(99);
        ecall_ev(32'd1); idle_cyc(1);
        chk("edge99_pass", 64'(a_pass[0]), 64'd1);
        chk("edge99_timeout", 64'(a_tmo[0]), 64'd0);
        chk("edge99_cycles", 64'(a_cyc[0]), 64'd99);
        chk("edge99_mode1_tmo", 64'(a_tmo[1]), 64'd1);

        go(); idle_cyc(30);
        go(); idle_cyc(5);
        chk("midrun_restart_cycles", 64'(a_cyc[0]), 64'd4);
        chk("midrun_restart_done", 64'(a_done[0]), 64'd0);

        idle_cyc(16);
        #2 rst = 0;
        #1;
        chk("async_rst_cycles", 64'(a_cyc[0]), 64'd0);
        chk("async_rst_done", 64'(a_done[1]), 64'd0);
        @(negedge clk);
        rst = 1;
        ecall_ev(32'd1); idle_cyc(1);
        chk("post_rst_ignored", 64'(a_done[0]), 64'd0);
        go(); idle_cyc(3);
        ecall_ev(32'd1); idle_cyc(1);
        chk("post_rst_pass", 64'(a_pass[0]), 64'd1);
        chk("post_rst_cycles", 64'(a_cyc[0]), 64'd3);

        go(); idle_cyc(10000);
        chk("no_tmo_done", 64'(a_done[2]), 64'd0);
        chk("no_tmo_cycles", 64'(a_cyc[2]), 64'd9999);
        chk("sat_cycles", 64'(a_cyc[3]), 64'd15);
        chk("long_tmo_cycles", 64'(a_cyc[0]), 64'd99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=expired required=finished");
        $fatal(1);
    end

endmodule
